uart_seed_loader: RTL

Receives the 512-bit encapsulation seed over a UART serial line (8N1), packs the bytes into sixteen 32-bit words, and presents them to `encap_seq_gen` as a burst on its `seed_valid`/`seed` input. It sits directly upstream of the encapsulation core on the FPGA top level. It replaces the seed ROM used in bring-up, so the seed can be supplied by a host PC.

---
 rtl/uart_seed_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_seed_loader.sv
// 8N1 UART receiver that packs 64 bytes big-endian into SEED_WORDS words, then bursts them out one per cycle.
// seed_valid rises 2 cycles after the last stop-bit sample; there is no downstream back-pressure.
module uart_seed_loader #(
    parameter int CLOCK_FPGA   = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLOCK_FPGA / BAUD_RATE,
    parameter int SEED_WORDS   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        seed_valid,
    output logic [31:0] seed,
    output logic        load_done,
    output logic        busy,
    output logic        frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int WW = $clog2(SEED_WORDS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] LAST_W  = WW'(SEED_WORDS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {ST_COLLECT, ST_STREAM, ST_DONE} st_state_t;

    logic            rx_meta_q, rx_s_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    st_state_t       st_q, st_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [WW-1:0]   word_idx_q, word_idx_d;
    logic [23:0]     hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            seed_valid_q, seed_valid_d;
    logic [31:0]     seed_q, seed_d;
    logic            load_done_q, load_done_d;
    logic [31:0]     buffer_q [SEED_WORDS];

    logic            byte_valid, frame_err_c, start_entry, glitch, wr_en, seed_empty;

    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_valid  = 1'b0;
        frame_err_c = 1'b0;
        start_entry = 1'b0;
        glitch      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    rx_state_d  = RX_START;
                    start_entry = 1'b1;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (rx_s_q) begin
                        rx_state_d = RX_IDLE;
                        glitch     = 1'b1;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s_q) byte_valid  = 1'b1;
                    else        frame_err_c = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign seed_empty = (byte_idx_q == 2'd0) && (word_idx_q == '0) && (st_q == ST_COLLECT);

    always_comb begin
        st_d         = st_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        hold_d       = hold_q;
        busy_d       = busy_q;
        wr_en        = 1'b0;
        case (st_q)
            ST_COLLECT: begin
                if (frame_err_c) begin
                    byte_idx_d = '0;
                    word_idx_d = '0;
                end else if (byte_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    hold_d     = {hold_q[15:0], shift_q};
                    if (byte_idx_q == 2'd3) begin
                        wr_en      = 1'b1;
                        word_idx_d = word_idx_q + WW'(1);
                        if (word_idx_q == LAST_W) st_d = ST_STREAM;
                    end
                end
            end
            // word_idx doubles as the read pointer; it wraps back to 0 at the end.
            ST_STREAM: begin
                word_idx_d = word_idx_q + WW'(1);
                if (word_idx_q == LAST_W) st_d = ST_DONE;
            end
            ST_DONE: st_d = ST_COLLECT;
            default: st_d = ST_COLLECT;
        endcase

        if (start_entry && seed_empty) busy_d = 1'b1;
        if (glitch && seed_empty)      busy_d = 1'b0;
        if (frame_err_c)               busy_d = 1'b0;
        // A byte of the next seed may already be arriving when the burst ends.
        if (st_q == ST_DONE)           busy_d = (rx_state_q != RX_IDLE) || start_entry;

        seed_valid_d = (st_q == ST_STREAM);
        seed_d       = (st_q == ST_STREAM) ? buffer_q[word_idx_q] : seed_q;
        load_done_d  = (st_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            st_q         <= ST_COLLECT;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            hold_q       <= '0;
            busy_q       <= 1'b0;
            seed_valid_q <= 1'b0;
            seed_q       <= '0;
            load_done_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            st_q         <= st_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            seed_valid_q <= seed_valid_d;
            seed_q       <= seed_d;
            load_done_q  <= load_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buffer_q[word_idx_q] <= {hold_q, shift_q};
    end

    assign seed_valid = seed_valid_q;
    assign seed       = seed_q;
    assign load_done  = load_done_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_c & ~rst;

endmodule
